// File: rtl/dac_driver_array.sv
// dac_driver_array: screened, power-sequenced switch driver for a segmented current-steering DAC
module dac_driver_array #(
  parameter int NBIN       = 8,
  parameter int NTHERM     = 17,
  parameter int SETTLE_CYC = 16,
  parameter int ERRW       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pdb,
  input  logic              supply_ok,
  input  logic [NBIN-1:0]   datain,
  input  logic [NBIN-1:0]   datainb,
  input  logic [NTHERM-1:0] datatherm,
  input  logic [NTHERM-1:0] datathermb,
  input  logic              err_clr,
  output logic [NBIN-1:0]   databinout,
  output logic [NBIN-1:0]   databinoutb,
  output logic [NTHERM-1:0] datathermout,
  output logic [NTHERM-1:0] datathermoutb,
  output logic              ready,
  output logic              err,
  output logic [ERRW-1:0]   err_cnt
);
  typedef enum logic [1:0] {OFF, SETTLE, ACTIVE} state_t;
  localparam logic [15:0] CNT_INIT = 16'(SETTLE_CYC - 1);
  state_t state, nstate;
  logic [15:0] cnt;
  logic [NBIN-1:0] s_bin, s_binb;
  logic [NTHERM-1:0] s_th, s_thb;
  logic [NTHERM:0] th_ext;
  logic en, valid, bad;
  assign en = pdb & supply_ok;
  assign th_ext = {1'b0, s_th};
  assign valid = (s_bin == ~s_binb) && (s_th == ~s_thb) &&
                 ((th_ext & (th_ext + {{NTHERM{1'b0}}, 1'b1})) == '0);
  assign ready = state == ACTIVE;
  // next state; screening only applies while staying in ACTIVE
  always_comb begin
    nstate = !en ? OFF :
             state == OFF ? SETTLE :
             (state == SETTLE && cnt == '0) ? ACTIVE : state;
    bad = state == ACTIVE && nstate == ACTIVE && !valid;
  end
  // stage-1 capture, state register and settle counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= OFF;
      cnt    <= '0;
      s_bin  <= '0;
      s_binb <= '0;
      s_th   <= '0;
      s_thb  <= '0;
    end else begin
      state  <= nstate;
      cnt    <= nstate != SETTLE ? '0 : state == SETTLE ? cnt - 16'd1 : CNT_INIT;
      s_bin  <= datain;
      s_binb <= datainb;
      s_th   <= datatherm;
      s_thb  <= datathermb;
    end
  end
  // output register: open switches, zero code, or last good screened code
  always_ff @(posedge clk) begin
    if (rst) begin
      databinout    <= '0;
      databinoutb   <= '0;
      datathermout  <= '0;
      datathermoutb <= '0;
      err           <= 1'b0;
      err_cnt       <= '0;
    end else begin
      err <= bad;
      if (err_clr) err_cnt <= '0;
      else if (bad && err_cnt != '1) err_cnt <= err_cnt + ERRW'(1);
      if (nstate == OFF) begin
        databinout    <= '0;
        databinoutb   <= '0;
        datathermout  <= '0;
        datathermoutb <= '0;
      end else if (nstate == SETTLE || state != ACTIVE) begin
        databinout    <= '0;
        databinoutb   <= '1;
        datathermout  <= '0;
        datathermoutb <= '1;
      end else if (valid) begin
        databinout    <= s_bin;
        databinoutb   <= s_binb;
        datathermout  <= s_th;
        datathermoutb <= s_thb;
      end
    end
  end
endmodule

// File: tb/tb_dac_driver_array.sv
// tb_dac_driver_array: scoreboard bench for dac_driver_array with directed vectors
module tb_dac_driver_array;
  typedef struct {
    string       name;
    logic [7:0]  bin, binb;
    logic [16:0] th, thb;
    logic        rdy, err;
    logic [1:0]  cnt;
  } exp_t;
  logic clk = 1'b0, rst, pdb, supply_ok, err_clr;
  logic [7:0] datain, datainb, databinout, databinoutb;
  logic [16:0] datatherm, datathermb, datathermout, datathermoutb;
  logic ready, err;
  logic [1:0] err_cnt;
  exp_t q[$];
  int n_run = 0, n_fail = 0;
  logic [1:0] sat_exp [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
  dac_driver_array #(.NBIN(8), .NTHERM(17), .SETTLE_CYC(16), .ERRW(2)) dut (
    .clk(clk), .rst(rst), .pdb(pdb), .supply_ok(supply_ok),
    .datain(datain), .datainb(datainb), .datatherm(datatherm), .datathermb(datathermb),
    .err_clr(err_clr), .databinout(databinout), .databinoutb(databinoutb),
    .datathermout(datathermout), .datathermoutb(datathermoutb),
    .ready(ready), .err(err), .err_cnt(err_cnt)
  );
  always #5 clk = ~clk;
  // monitor: after every edge, check the output against the oldest queued expectation
  initial forever begin
    @(posedge clk);
    #1;
    if (q.size() != 0) begin
      automatic exp_t e = q.pop_front();
      n_run++;
      if (databinout !== e.bin || databinoutb !== e.binb || datathermout !== e.th ||
          datathermoutb !== e.thb || ready !== e.rdy || err !== e.err || err_cnt !== e.cnt) begin
        n_fail++;
        $display("FAIL %s: got bin=%h binb=%h th=%h thb=%h rdy=%b err=%b cnt=%0d, want bin=%h binb=%h th=%h thb=%h rdy=%b err=%b cnt=%0d",
                 e.name, databinout, databinoutb, datathermout, datathermoutb, ready, err, err_cnt,
                 e.bin, e.binb, e.th, e.thb, e.rdy, e.err, e.cnt);
      end
    end
  end
  task automatic tick(input string n, input logic [7:0] b, bb, input logic [16:0] t, tb,
                      input logic r, e, input logic [1:0] c);
    q.push_back('{n, b, bb, t, tb, r, e, c});
    @(posedge clk);
    #2;
  endtask
  task automatic t_off(input string n, input logic [1:0] c);
    tick(n, 8'h00, 8'h00, 17'h0, 17'h0, 1'b0, 1'b0, c);
  endtask
  task automatic t_zc(input string n, input logic r, input logic [1:0] c);
    tick(n, 8'h00, 8'hFF, 17'h0, 17'h1FFFF, r, 1'b0, c);
  endtask
  task automatic t_d(input string n, input logic [7:0] b, input logic [16:0] t,
                     input logic e, input logic [1:0] c);
    tick(n, b, ~b, t, ~t, 1'b1, e, c);
  endtask
  task automatic set_in(input logic [7:0] b, bb, input logic [16:0] t, tb);
    datain = b;
    datainb = bb;
    datatherm = t;
    datathermb = tb;
  endtask
  initial begin
    rst = 1'b1; pdb = 1'b1; supply_ok = 1'b1; err_clr = 1'b0;
    set_in(8'h00, 8'hFF, 17'h0, 17'h1FFFF);
    t_off("rst0", 0);
    t_off("rst1", 0);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) t_zc("settle", 1'b0, 0);
    t_zc("ready_rise", 1'b1, 0);
    set_in(8'hCC, 8'h33, 17'h000FF, 17'h1FF00);
    t_d("lat_edge1", 8'h00, 17'h0, 1'b0, 0);
    t_d("lat_edge2", 8'hCC, 17'h000FF, 1'b0, 0);
    set_in(8'hCC, 8'h33, 17'h15555, 17'h0AAAA);
    t_d("nontherm_cap", 8'hCC, 17'h000FF, 1'b0, 0);
    set_in(8'hCC, 8'hCC, 17'h000FF, 17'h1FF00);
    t_d("nontherm_hold", 8'hCC, 17'h000FF, 1'b1, 1);
    set_in(8'hA5, 8'h5A, 17'h1FFFF, 17'h00000);
    t_d("mismatch_hold", 8'hCC, 17'h000FF, 1'b1, 2);
    t_d("all_ones", 8'hA5, 17'h1FFFF, 1'b0, 2);
    rst = 1'b1;
    t_off("rst_mid", 0);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) t_zc("settle_b", 1'b0, 0);
    t_zc("ready_b", 1'b1, 0);
    t_d("resume", 8'hA5, 17'h1FFFF, 1'b0, 0);
    datainb = 8'hA5;
    t_d("sat_cap", 8'hA5, 17'h1FFFF, 1'b0, 0);
    for (int i = 0; i < 5; i++) t_d("sat", 8'hA5, 17'h1FFFF, 1'b1, sat_exp[i]);
    err_clr = 1'b1;
    set_in(8'h3C, 8'hC3, 17'h00001, 17'h1FFFE);
    t_d("clr_wins", 8'hA5, 17'h1FFFF, 1'b1, 0);
    err_clr = 1'b0;
    t_d("after_clr", 8'h3C, 17'h00001, 1'b0, 0);
    supply_ok = 1'b0;
    t_off("pwr_down", 0);
    t_off("pwr_down_hold", 0);
    supply_ok = 1'b1;
    for (int i = 0; i < 3; i++) t_zc("settle_c", 1'b0, 0);
    pdb = 1'b0;
    t_off("settle_abort", 0);
    pdb = 1'b1;
    datainb = datain;
    for (int i = 0; i < 16; i++) t_zc("resettle_noerr", 1'b0, 0);
    t_zc("ready_c", 1'b1, 0);
    t_d("inv_in_active", 8'h00, 17'h0, 1'b1, 1);
    @(posedge clk);
    #3;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations unchecked, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
